hood_panel_ctrl: RTL

HOOD_PANEL_CTRL -- requirements
Module: hood_panel_ctrl

---
 rtl/hood_pkg.sv | 48 ++++
 rtl/hood_panel_ctrl_if.sv | 29 ++
 rtl/hood_panel_ctrl_btn_debounce.sv | 48 ++++
 rtl/hood_panel_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// hood_pkg: shared types, mode encodings and default parameters for the hood control panel.
//   Provides the FSM state enum, the prioritised button event enum, button
//   bit positions within the raw/press vectors, and the state-to-mode mapping.
package hood_pkg;

    localparam int DEF_DEB_CYCLES   = 20;
    localparam int DEF_MENU_TIMEOUT = 100;
    localparam int DEF_EXIT_DELAY   = 60;

    localparam logic [2:0] MODE_IDLE      = 3'd0;
    localparam logic [2:0] MODE_LVL1      = 3'd1;
    localparam logic [2:0] MODE_LVL2      = 3'd2;
    localparam logic [2:0] MODE_HURRICANE = 3'd3;

    localparam int BTN_POWER = 0;
    localparam int BTN_MENU  = 1;
    localparam int BTN_MODE1 = 2;
    localparam int BTN_MODE2 = 3;
    localparam int BTN_MODE3 = 4;
    localparam int NUM_BTNS  = 5;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_STANDBY,
        ST_MENU,
        ST_LVL1,
        ST_LVL2,
        ST_LVL3,
        ST_EXIT_WAIT
    } hood_state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_POWER,
        EV_MENU,
        EV_MODE3,
        EV_MODE2,
        EV_MODE1
    } hood_evt_e;

    // EXIT_WAIT keeps the fan at level 2 while the hurricane spins down.
    function automatic logic [2:0] mode_of(hood_state_e s);
        return s == ST_LVL1 ? MODE_LVL1 :
               (s == ST_LVL2 || s == ST_EXIT_WAIT) ? MODE_LVL2 :
               s == ST_LVL3 ? MODE_HURRICANE : MODE_IDLE;
    endfunction

endpackage

// File: rtl/hood_panel_ctrl_if.sv
// hood_panel_ctrl_if: panel-side signal bundle of the hood controller.
//   master: drives the raw buttons and hurricane_done, observes the outputs.
//   slave : the controller; samples the inputs, drives mode_state, power_on,
//           menu_active, hurricane_avail and cmd_valid.
interface hood_panel_ctrl_if;

    logic       power_btn;
    logic       menu_btn;
    logic       mode1_btn;
    logic       mode2_btn;
    logic       mode3_btn;
    logic       hurricane_done;
    logic [2:0] mode_state;
    logic       power_on;
    logic       menu_active;
    logic       hurricane_avail;
    logic       cmd_valid;

    modport master (
        output power_btn, menu_btn, mode1_btn, mode2_btn, mode3_btn, hurricane_done,
        input  mode_state, power_on, menu_active, hurricane_avail, cmd_valid
    );

    modport slave (
        input  power_btn, menu_btn, mode1_btn, mode2_btn, mode3_btn, hurricane_done,
        output mode_state, power_on, menu_active, hurricane_avail, cmd_valid
    );

endinterface

// File: rtl/hood_panel_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, debouncer and rising-edge press detector for one button.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous active-high button
//   press      : one-cycle pulse when the debounced level rises
module btn_debounce
    import hood_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synchronized samples that differ from level;
    // a sample matching level restarts it, so it never exceeds DEB_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt   <= '0;
                level <= s2;
                press <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hood_panel_ctrl.sv
// hood_panel_ctrl: range-hood front-panel controller (buttons -> fan mode command).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of hood_panel_ctrl_if (raw buttons and hurricane_done in;
//                mode_state, power_on, menu_active, hurricane_avail, cmd_valid out)
module hood_panel_ctrl
    import hood_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int MENU_TIMEOUT = DEF_MENU_TIMEOUT,
    parameter int EXIT_DELAY   = DEF_EXIT_DELAY
) (
    input logic clk,
    input logic rst_n,
    hood_panel_ctrl_if.slave bus
);

    localparam int MCW = $clog2(MENU_TIMEOUT + 1);
    localparam int XCW = $clog2(EXIT_DELAY + 1);

    logic [NUM_BTNS-1:0] raw;
    logic [NUM_BTNS-1:0] press;
    hood_state_e         state;
    hood_state_e         state_n;
    hood_evt_e           evt;
    logic                avail;
    logic                avail_n;
    logic [MCW-1:0]      mcnt;
    logic [MCW-1:0]      mcnt_n;
    logic [MCW-1:0]      minc;
    logic [XCW-1:0]      xcnt;
    logic [XCW-1:0]      xcnt_n;
    logic [XCW-1:0]      xinc;
    logic [2:0]          mode_state;
    logic                power_on;
    logic                menu_active;
    logic                cmd_valid;

    assign raw[BTN_POWER] = bus.power_btn;
    assign raw[BTN_MENU]  = bus.menu_btn;
    assign raw[BTN_MODE1] = bus.mode1_btn;
    assign raw[BTN_MODE2] = bus.mode2_btn;
    assign raw[BTN_MODE3] = bus.mode3_btn;

    genvar i;
    for (i = 0; i < NUM_BTNS; i++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[i]),
            .press (press[i])
        );
    end

    // Only the highest-priority pulse of a cycle survives, even if the
    // current state then ignores it.
    assign evt = press[BTN_POWER] ? EV_POWER :
                 press[BTN_MENU]  ? EV_MENU  :
                 press[BTN_MODE3] ? EV_MODE3 :
                 press[BTN_MODE2] ? EV_MODE2 :
                 press[BTN_MODE1] ? EV_MODE1 : EV_NONE;

    assign minc = mcnt == MCW'(MENU_TIMEOUT) ? mcnt : mcnt + 1'b1;
    assign xinc = xcnt == XCW'(EXIT_DELAY) ? xcnt : xcnt + 1'b1;

    // Counters are zero outside their own state, which clears them on entry.
    always_comb begin
        state_n = state;
        avail_n = avail;
        mcnt_n  = '0;
        xcnt_n  = '0;
        if (evt == EV_POWER) begin
            state_n = state == ST_OFF ? ST_STANDBY : ST_OFF;
            avail_n = state == ST_OFF ? 1'b1 : avail;
        end else begin
            case (state)
                ST_STANDBY: state_n = evt == EV_MENU ? ST_MENU : ST_STANDBY;
                ST_MENU: begin
                    if (evt == EV_MENU) begin
                        state_n = ST_STANDBY;
                    end else if (evt == EV_MODE1) begin
                        state_n = ST_LVL1;
                    end else if (evt == EV_MODE2) begin
                        state_n = ST_LVL2;
                    end else if (evt == EV_MODE3 && avail) begin
                        state_n = ST_LVL3;
                        avail_n = 1'b0;
                    end else if (minc == MCW'(MENU_TIMEOUT)) begin
                        state_n = ST_STANDBY;
                    end else begin
                        mcnt_n = minc;
                    end
                end
                ST_LVL1: state_n = evt == EV_MODE2 ? ST_LVL2 : evt == EV_MENU ? ST_STANDBY : ST_LVL1;
                ST_LVL2: state_n = evt == EV_MODE1 ? ST_LVL1 : evt == EV_MENU ? ST_STANDBY : ST_LVL2;
                ST_LVL3: state_n = evt == EV_MENU ? ST_EXIT_WAIT : bus.hurricane_done ? ST_LVL2 : ST_LVL3;
                ST_EXIT_WAIT: begin
                    if (xinc == XCW'(EXIT_DELAY)) begin
                        state_n = ST_STANDBY;
                    end else begin
                        xcnt_n = xinc;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            avail       <= 1'b1;
            mcnt        <= '0;
            xcnt        <= '0;
            mode_state  <= MODE_IDLE;
            power_on    <= 1'b0;
            menu_active <= 1'b0;
            cmd_valid   <= 1'b0;
        end else begin
            state       <= state_n;
            avail       <= avail_n;
            mcnt        <= mcnt_n;
            xcnt        <= xcnt_n;
            mode_state  <= mode_of(state_n);
            power_on    <= state_n != ST_OFF;
            menu_active <= state_n == ST_MENU;
            cmd_valid   <= mode_of(state_n) != mode_state;
        end
    end

    assign bus.mode_state      = mode_state;
    assign bus.power_on        = power_on;
    assign bus.menu_active     = menu_active;
    assign bus.hurricane_avail = avail;
    assign bus.cmd_valid       = cmd_valid;

endmodule
